// File: rtl/datapath_controller_pkg.sv
// Shared definitions for the datapath controller: opcodes, FSM states,
// instruction field positions and the immediate extender.
package datapath_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 6;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_EXEC     = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_e;

    typedef struct packed {
        logic legal;
        logic wr_reg;
        logic use_imm;
        logic is_load;
        logic is_store;
        logic is_halt;
    } dec_t;

    function automatic logic [31:0] ext_imm(input logic [5:0] imm, input bit sign_ext);
        return sign_ext ? {{26{imm[5]}}, imm} : {26'b0, imm};
    endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction handshake and data-memory handshake between the controller
// (slave) and its environment (master).
interface datapath_controller_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;

    modport master (
        output instr, instr_valid, mem_ready,
        input  instr_ready, mem_read, mem_write
    );

    modport slave (
        input  instr, instr_valid, mem_ready,
        output instr_ready, mem_read, mem_write
    );
endinterface

// File: rtl/datapath_controller_decode.sv
// Opcode decoder: maps the latched opcode to control classes and a legal flag.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        dec.legal = 1'b1;
        case (opcode)
            OP_NOP:   ;
            OP_ADD:   dec.wr_reg = 1'b1;
            OP_ADDI: begin
                dec.wr_reg  = 1'b1;
                dec.use_imm = 1'b1;
            end
            OP_LOAD:  dec.is_load  = 1'b1;
            OP_STORE: dec.is_store = 1'b1;
            OP_HALT:  dec.is_halt  = 1'b1;
            default:  dec.legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Instruction sequencer driving the register-file datapath control word.
//   state      | meaning
//   S_FETCH    | instr_ready high (once out of reset), latch instr on handshake
//   S_EXEC     | one cycle: drive control word, retire or start memory access
//   S_MEM_WAIT | hold memory request until mem_ready or timeout
//   S_HALT     | halted, only reset leaves
module datapath_controller
    import datapath_ctrl_pkg::*;
#(
    parameter bit IMM_SIGN_EXT = 1'b1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.slave  bus,
    output logic                  load_enable,
    output logic [1:0]            dest_select,
    output logic [1:0]            A_select,
    output logic [1:0]            B_select,
    output logic                  mb_select,
    output logic                  md_select,
    output logic [31:0]           constant_in,
    output logic                  halted,
    output logic                  illegal_op,
    output logic                  mem_error,
    output logic [15:0]           retired_count
);

    localparam logic [7:0] TMO_LOAD = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] ir_q;
    logic [7:0]  timer_q, timer_d;
    logic        run_q;
    logic        mem_error_q, mem_error_d;
    logic        retire;
    logic        accept;
    dec_t        dec;

    logic [1:0] rd, ra, rb;
    assign rd = ir_q[RD_MSB:RD_LSB];
    assign ra = ir_q[RA_MSB:RA_LSB];
    assign rb = ir_q[RB_MSB:RB_LSB];

    datapath_ctrl_decode u_decode (
        .opcode (ir_q[OPC_MSB:OPC_LSB]),
        .dec    (dec)
    );

    // run_q keeps instr_ready low during the reset cycles themselves
    assign accept = (state_q == S_FETCH) && run_q && bus.instr_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            ir_q          <= '0;
            timer_q       <= '0;
            run_q         <= 1'b0;
            mem_error_q   <= 1'b0;
            retired_count <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            run_q       <= 1'b1;
            mem_error_q <= mem_error_d;
            if (accept)
                ir_q <= bus.instr;
            if (retire)
                retired_count <= retired_count + 16'd1;
        end
    end

    assign mem_error = mem_error_q;

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        mem_error_d     = 1'b0;
        retire          = 1'b0;
        bus.instr_ready = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        load_enable     = 1'b0;
        dest_select     = 2'd0;
        A_select        = 2'd0;
        B_select        = 2'd0;
        mb_select       = 1'b0;
        md_select       = 1'b0;
        constant_in     = 32'd0;
        halted          = 1'b0;
        illegal_op      = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.instr_ready = run_q;
                if (accept)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (!dec.legal) begin
                    illegal_op = 1'b1;
                end else if (dec.is_load || dec.is_store) begin
                    A_select      = ra;
                    B_select      = dec.is_store ? rb : 2'd0;
                    bus.mem_read  = dec.is_load;
                    bus.mem_write = dec.is_store;
                    timer_d       = TMO_LOAD;
                    state_d       = S_MEM_WAIT;
                end else begin
                    retire = 1'b1;
                    if (dec.wr_reg) begin
                        A_select    = ra;
                        B_select    = rb;
                        dest_select = rd;
                        mb_select   = dec.use_imm;
                        load_enable = 1'b1;
                        if (dec.use_imm)
                            constant_in = ext_imm(ir_q[IMM_MSB:IMM_LSB], IMM_SIGN_EXT);
                    end
                    if (dec.is_halt)
                        state_d = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                A_select      = ra;
                B_select      = dec.is_store ? rb : 2'd0;
                bus.mem_read  = dec.is_load;
                bus.mem_write = dec.is_store;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (dec.is_load) begin
                        load_enable = 1'b1;
                        md_select   = 1'b1;
                        dest_select = rd;
                    end
                end else if (timer_q == 8'd0) begin
                    mem_error_d = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

endmodule
